operand_select_stage: RTL

OPERAND_SELECT_STAGE -- requirements
Module: operand_select_stage

---
 rtl/operand_select_stage_pkg.sv | 50 +++++
 rtl/fwd_mux.sv | 27 ++
 rtl/operand_select_stage.sv | 112 +++++++++++
 3 files changed

// File: rtl/operand_select_stage_pkg.sv
// Shared definitions for the operand-select stage: instruction frame, RISC-V major
// opcodes and the operand select kinds decoded from them.
package operand_select_stage_pkg;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } src_frame_t;

    localparam logic [6:0] OpcR  = 7'b0110011;
    localparam logic [6:0] OpcI1 = 7'b0010011;
    localparam logic [6:0] OpcI2 = 7'b0000011;
    localparam logic [6:0] OpcI3 = 7'b1100111;
    localparam logic [6:0] OpcU1 = 7'b0110111;
    localparam logic [6:0] OpcU2 = 7'b0010111;
    localparam logic [6:0] OpcS  = 7'b0100011;
    localparam logic [6:0] OpcB  = 7'b1100011;
    localparam logic [6:0] OpcJ  = 7'b1101111;
    localparam logic [6:0] OpcE  = 7'b1110011;

    typedef enum logic [1:0] {Op1Rs1, Op1Pc, Op1Zero} op1_sel_e;
    typedef enum logic [1:0] {Op2Rs2, Op2Imm, Op2Link, Op2Rexp} op2_sel_e;

    function automatic op1_sel_e decode_op1(input logic [6:0] opc);
        case (opc)
            OpcJ, OpcU2: return Op1Pc;
            OpcU1:       return Op1Zero;
            default:     return Op1Rs1;
        endcase
    endfunction

    function automatic op2_sel_e decode_op2(input logic [6:0] opc);
        case (opc)
            OpcI1, OpcI2, OpcU1, OpcU2, OpcS, OpcB: return Op2Imm;
            OpcJ, OpcI3:                            return Op2Link;
            OpcE:                                   return Op2Rexp;
            default:                                return Op2Rs2;
        endcase
    endfunction

    function automatic logic reads_rs1(input logic [6:0] opc);
        return !(opc == OpcJ || opc == OpcU1 || opc == OpcU2);
    endfunction

    function automatic logic reads_rs2(input logic [6:0] opc);
        return (opc == OpcR || opc == OpcS || opc == OpcB);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Forwarding priority mux: lowest-index matching port wins; register x0 always reads 0.
module fwd_mux #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NFWD = 2
) (
    input  logic [4:0]         addr,
    input  logic [XLEN-1:0]    reg_value,
    input  logic [NFWD-1:0]    fwd_valid,
    input  logic [5*NFWD-1:0]  fwd_addr,
    input  logic [XLEN*NFWD-1:0] fwd_data,
    output logic [XLEN-1:0]    value
);

    always_comb begin
        value = reg_value;
        // Scan oldest to youngest so the youngest match overwrites last.
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && fwd_addr[5*i +: 5] == addr) begin
                value = fwd_data[XLEN*i +: XLEN];
            end
        end
        if (addr == 5'd0) begin
            value = '0;
        end
    end

endmodule

// File: rtl/operand_select_stage.sv
// Operand-select pipeline stage: forwards sources, picks operands by opcode, stalls on
// load-use hazards and registers the result behind a valid/ready handshake.
module operand_select_stage
    import operand_select_stage_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NFWD        = 2,
    parameter int unsigned LINK_OFFSET = 4,
    parameter int unsigned CNTW        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           opcode,
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    input  logic [XLEN-1:0]      rs1_value,
    input  logic [XLEN-1:0]      rs2_value,
    input  logic [XLEN-1:0]      imm,
    input  logic [XLEN-1:0]      pc,
    input  logic [XLEN-1:0]      rexp_value,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [5*NFWD-1:0]    fwd_addr,
    input  logic [XLEN*NFWD-1:0] fwd_data,
    input  logic                 load_pending,
    input  logic [4:0]           load_rd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      oprand_1,
    output logic [XLEN-1:0]      oprand_2,
    output logic [CNTW-1:0]      stall_cnt
);

    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic [XLEN-1:0] op1_d, op2_d, op1_q, op2_q;
    logic            valid_q;
    logic [CNTW-1:0] stall_cnt_q;
    logic            hazard, capture;
    op1_sel_e        op1_sel;
    op2_sel_e        op2_sel;

    fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd_rs1 (
        .addr      (rs1_addr),
        .reg_value (rs1_value),
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .value     (rs1_fwd)
    );

    fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd_rs2 (
        .addr      (rs2_addr),
        .reg_value (rs2_value),
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .value     (rs2_fwd)
    );

    always_comb begin
        op1_sel = decode_op1(opcode);
        op2_sel = decode_op2(opcode);
        hazard  = load_pending && (load_rd != 5'd0) &&
                  ((reads_rs1(opcode) && load_rd == rs1_addr) ||
                   (reads_rs2(opcode) && load_rd == rs2_addr));
        in_ready = rst_n && (!valid_q || out_ready) && !hazard && !flush;
        capture  = in_valid && in_ready;

        case (op1_sel)
            Op1Pc:   op1_d = pc;
            Op1Zero: op1_d = '0;
            default: op1_d = rs1_fwd;
        endcase

        case (op2_sel)
            Op2Imm:  op2_d = imm;
            Op2Link: op2_d = XLEN'(LINK_OFFSET);
            Op2Rexp: op2_d = rexp_value;
            default: op2_d = rs2_fwd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (capture) begin
                valid_q <= 1'b1;
                op1_q   <= op1_d;
                op2_q   <= op2_d;
            end else if (valid_q && out_ready) begin
                valid_q <= 1'b0;
            end
            if (in_valid && hazard && !flush && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + CNTW'(1);
            end
        end
    end

    assign out_valid = valid_q;
    assign oprand_1  = op1_q;
    assign oprand_2  = op2_q;
    assign stall_cnt = stall_cnt_q;

endmodule
